// File: rtl/ddr_test_seq_ctrl.sv
// ============================================================================
// Module  : ddr_test_seq_ctrl
// Brief   : DDR3 AXI traffic-test sequencer: one-shot init, then LFSR-driven
//           write/read-back command pairs. Optional: DDR_TEST_STOP_ON_ERR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ddr_test_seq_ctrl #(
  parameter int          CTRL_ADDR_WIDTH = 28,
  parameter int          MEM_SPACE_AW    = 18,
  parameter logic [31:0] LFSR_SEED       = 32'h1357_9BDF,
  parameter int          NUM_ITER        = 0,
  parameter int          RD_GAP          = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       test_start,
  input  logic                       init_done,
  output logic                       init_start,
  output logic                       write_en,
  input  logic                       write_done_p,
  output logic                       read_en,
  input  logic                       read_done_p,
  input  logic                       err_flag,
  output logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  output logic [3:0]                 random_axi_id,
  output logic [3:0]                 random_axi_len,
  output logic                       err_latched,
  output logic                       test_done,
  output logic [31:0]                wr_cmd_cnt,
  output logic [31:0]                rd_cmd_cnt,
  output logic [2:0]                 state_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_STOP = 3'd6;

  // Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [7:0]  GAP_LAST  = 8'(RD_GAP - 1);
  localparam logic [31:0] ITER_W    = 32'(NUM_ITER);

`ifdef DDR_TEST_STOP_ON_ERR_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic [2:0]                 state_q, state_d;
  logic [31:0]                lfsr_q, lfsr_d;
  logic                       init_latch_q, init_latch_d;
  logic                       init_start_q, init_start_d;
  logic                       write_en_q, write_en_d;
  logic                       read_en_q, read_en_d;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]                 id_q, id_d;
  logic [3:0]                 len_q, len_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic [31:0]                wr_cnt_q, wr_cnt_d;
  logic [31:0]                rd_cnt_q, rd_cnt_d;
  logic [31:0]                pair_q, pair_d;
  logic [7:0]                 gap_q, gap_d;
  logic [31:0]                w_lfsr_next;
  logic                       w_load;
  logic                       w_err;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
  endfunction

  assign w_lfsr_next = lfsr_step(lfsr_q);
  assign w_err       = err_q | err_flag;

  always_comb begin
    state_d      = state_q;
    init_latch_d = init_latch_q;
    init_start_d = init_start_q;
    write_en_d   = write_en_q;
    read_en_d    = read_en_q;
    err_d        = w_err;
    done_d       = done_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    pair_d       = pair_q;
    gap_d        = gap_q;
    w_load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (STOP_EN && w_err) begin
          state_d = S_STOP;
        end else if (test_start) begin
          if (!init_latch_q) begin
            state_d      = S_INIT;
            init_start_d = 1'b1;
          end else begin
            state_d    = S_WR;
            write_en_d = 1'b1;
            w_load     = 1'b1;
          end
        end
      end
      S_INIT: begin
        // init_start drops first; the write is launched one edge later
        if (init_latch_q) begin
          state_d    = S_WR;
          write_en_d = 1'b1;
          w_load     = 1'b1;
        end else if (init_done) begin
          init_start_d = 1'b0;
          init_latch_d = 1'b1;
        end
      end
      S_WR: begin
        if (write_done_p) begin
          write_en_d = 1'b0;
          wr_cnt_d   = wr_cnt_q + 32'd1;
          gap_d      = 8'd0;
          state_d    = (STOP_EN && w_err) ? S_STOP : S_GAP;
        end
      end
      S_GAP: begin
        if (STOP_EN && w_err) begin
          state_d = S_STOP;
        end else if (gap_q == GAP_LAST) begin
          state_d   = S_RD;
          read_en_d = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_RD: begin
        if (read_done_p) begin
          read_en_d = 1'b0;
          rd_cnt_d  = rd_cnt_q + 32'd1;
          pair_d    = pair_q + 32'd1;
          if (STOP_EN && w_err) begin
            state_d = S_STOP;
          end else if ((ITER_W != 32'd0) && (pair_d == ITER_W)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (!test_start) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_WR;
            write_en_d = 1'b1;
            w_load     = 1'b1;
          end
        end
      end
      S_DONE, S_STOP: state_d = state_q;
      default:        state_d = S_IDLE;
    endcase
  end

  // Command fields are 128-unit aligned so a 16x8-unit burst stays in range
  always_comb begin
    lfsr_d = lfsr_q;
    addr_d = addr_q;
    id_d   = id_q;
    len_d  = len_q;
    if (w_load) begin
      lfsr_d                   = w_lfsr_next;
      id_d                     = w_lfsr_next[3:0];
      len_d                    = w_lfsr_next[7:4];
      addr_d                   = '0;
      addr_d[MEM_SPACE_AW-1:7] = w_lfsr_next[8 +: MEM_SPACE_AW-7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      init_latch_q <= 1'b0;
      init_start_q <= 1'b0;
      write_en_q   <= 1'b0;
      read_en_q    <= 1'b0;
      addr_q       <= '0;
      id_q         <= 4'd0;
      len_q        <= 4'd0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      wr_cnt_q     <= 32'd0;
      rd_cnt_q     <= 32'd0;
      pair_q       <= 32'd0;
      gap_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      init_latch_q <= init_latch_d;
      init_start_q <= init_start_d;
      write_en_q   <= write_en_d;
      read_en_q    <= read_en_d;
      addr_q       <= addr_d;
      id_q         <= id_d;
      len_q        <= len_d;
      err_q        <= err_d;
      done_q       <= done_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      pair_q       <= pair_d;
      gap_q        <= gap_d;
    end
  end

  assign init_start     = init_start_q;
  assign write_en       = write_en_q;
  assign read_en        = read_en_q;
  assign random_rw_addr = addr_q;
  assign random_axi_id  = id_q;
  assign random_axi_len = len_q;
  assign err_latched    = err_q;
  assign test_done      = done_q;
  assign wr_cmd_cnt     = wr_cnt_q;
  assign rd_cmd_cnt     = rd_cnt_q;
  assign state_dbg      = state_q;

endmodule

`default_nettype wire

// File: doc/ddr_test_seq_ctrl.md
Name: ddr_test_seq_ctrl

Overview:
- Top-level sequencer for the 128-bit AXI DDR3 traffic test. Drives the write controller's `init_start`/`write_en` and the read controller's `read_en`.
- Runs a one-shot memory init, then repeated write-then-read-back command pairs with pseudo-random address/ID/length from an internal LFSR.
- Counts issued commands, latches compare errors and reports completion. Sits between the board-level test start/status I/O and the write/read traffic controllers.

Parameters:
- CTRL_ADDR_WIDTH, 28, width of `random_rw_addr`.
- MEM_SPACE_AW, 18, log2 of tested address space in `random_rw_addr` units; legal range 8..31.
- LFSR_SEED, 32'h1357_9BDF, LFSR reset value; must be nonzero.
- NUM_ITER, 0, write/read pairs to run; 0 = run forever.
- RD_GAP, 32, idle cycles between `write_done_p` and assertion of `read_en`; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- test_start  in  1  level; high enables sequencing
- init_done  in  1  from write controller; memory init complete
- init_start  out  1  to write controller; init sweep request
- write_en  out  1  to write controller; request one write burst
- write_done_p  in  1  one-cycle pulse; write address accepted
- read_en  out  1  to read controller; request one read burst
- read_done_p  in  1  one-cycle pulse; read command accepted
- err_flag  in  1  one-cycle pulse; read-data compare mismatch
- random_rw_addr  out  CTRL_ADDR_WIDTH  command address
- random_axi_id  out  4  command ID
- random_axi_len  out  4  command length minus one
- err_latched  out  1  sticky error
- test_done  out  1  NUM_ITER pairs completed
- wr_cmd_cnt  out  32  write commands issued
- rd_cmd_cnt  out  32  read commands issued
- state_dbg  out  3  current state encoding

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous, active-high.
- Reset values:
  - All outputs 0.
  - LFSR = LFSR_SEED.
  - State = S_IDLE (encoding 0). Other encodings: S_INIT=1, S_WR=2, S_GAP=3, S_RD=4, S_DONE=5, S_STOP=6.
- S_IDLE:
  - If `test_start` is high: go to S_INIT when the `init_done` latch is 0, else to S_WR.
  - Outputs held at their current values.
- S_INIT:
  - `init_start`=1 (registered).
  - On sampling `init_done`=1: `init_start` goes to 0 on the next edge, the internal init latch is set, then go to S_WR.
  - Init runs once per reset only.
- Command load, on the transition into S_WR:
  - Advance the LFSR one step: Galois, taps x^32+x^22+x^2+x+1.
  - Register outputs from the new LFSR value L:
    - `random_axi_id` = L[3:0]
    - `random_axi_len` = L[7:4]
    - `random_rw_addr` = { zeros, L[8 +: MEM_SPACE_AW-7], 7'b0 }
  - Address is 128-unit aligned, so a 16-beat burst (8 units/beat) never crosses the space top or wraps. Bits at and above MEM_SPACE_AW are 0.
  - Address/ID/len stay stable until the next load.
- S_WR:
  - `write_en`=1.
  - On `write_done_p`: `write_en`=0 on the next edge, `wr_cmd_cnt`+1, clear the gap counter, go to S_GAP.
- S_GAP:
  - Count RD_GAP cycles, then go to S_RD. Enables are 0.
- S_RD:
  - `read_en`=1, using the same address/ID/len as the preceding write.
  - On `read_done_p`: `read_en`=0, `rd_cmd_cnt`+1, pair counter +1, then:
    - If NUM_ITER≠0 and pair count == NUM_ITER: go to S_DONE.
    - Else if `test_start`=0: go to S_IDLE.
    - Else: go to S_WR with a new command load.
- S_DONE: `test_done`=1. Leave only on `rst`.
- `test_start` falling mid-pair: ignored until the pair's `read_done_p`; an issued write is always read back.
- `err_flag`: sets `err_latched` in any state, including the same cycle as any other event. Cleared only by `rst`.
- Counters: 32-bit, wrap 0xFFFF_FFFF → 0.
- A done pulse arriving outside its own state (e.g. `read_done_p` in S_WR) is ignored.
- `write_en` and `read_en` are never high in the same cycle.
- `rst` mid-operation: all enables drop on the next edge, and the init latch is cleared, so init reruns.

Optional Feature:
- Macro: DDR_TEST_STOP_ON_ERR_EN.
- Defined:
  - `err_latched`=1 forces S_STOP after the in-flight command's done pulse. If in S_GAP or S_IDLE, S_STOP is entered immediately.
  - S_STOP holds all enables at 0, does not assert `test_done`, and is exited only by `rst`.
- Undefined: errors are latched only; sequencing continues, and S_STOP is unreachable.

Test Plan:
- `rst` high 3 cycles, then low with `test_start`=1 → `init_start`=1 the next cycle; `init_done` pulsed at cycle 50 → `init_start`=0 at cycle 51, `write_en`=1 at cycle 52.
- Seed default, first load → id/len/addr equal the model LFSR fields; `random_rw_addr`[6:0]=0 and bits ≥18 are 0, checked over 1000 loads.
- `write_done_p` at cycle T → `write_en` low at T+1, `read_en` high at T+1+32, same addr/id/len; `wr_cmd_cnt`=1.
- NUM_ITER=4 with a responder model → exactly 4 writes and 4 reads, then `test_done`=1, counts 4/4.
- `test_start` dropped while in S_WR → the read still issues, then state_dbg=0, no further `write_en`.
- `err_flag` pulse during S_GAP with DDR_TEST_STOP_ON_ERR_EN defined → `err_latched`=1, state_dbg=6 the next cycle, `read_en` never asserted; undefined → `read_en` asserts normally.
